// File: rtl/gmii_rx_frame_pkg.sv
// Shared constants and types for the GMII receive frame parser and the CRC helper.
package gmii_rx_frame_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  // Number of trailing FCS bytes held back from the payload stream
  localparam int FCS_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } rx_state_t;

endpackage

// File: rtl/gmii_rx_frame_if.sv
// Byte stream bundle of the receive parser: PHY-side input byte/control and
// the payload stream toward the packet layer. The parser uses the master view.
interface gmii_rx_frame_if;

  logic [7:0] rx_data;
  logic [1:0] rx_ctl;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_err;

  modport master (
    input  rx_data,
    input  rx_ctl,
    output out_data,
    output out_valid,
    output out_last,
    output out_err
  );

  modport slave (
    output rx_data,
    output rx_ctl,
    input  out_data,
    input  out_valid,
    input  out_last,
    input  out_err
  );

endinterface

// File: rtl/gmii_rx_frame_crc32_d8.sv
// Combinational CRC-32 update over one byte, LSB first as bits go on the wire.
// Shared with the transmit framer.
module crc32_d8
  import gmii_rx_frame_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  // Walk the reflected LFSR eight times, one data bit per step
  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ ({32{c[0] ^ data[i]}} & CRC32_POLY);
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_frame.sv
// Ethernet receive frame parser: strips preamble/SFD, holds back the FCS
// through a 4-byte window plus one pending byte, checks CRC/length/rx_er and
// emits payload as a valid/last/err stream. No backpressure is possible.
module gmii_rx_frame
  import gmii_rx_frame_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  gmii_rx_frame_if.master  bus,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_bad
);

  localparam int LEN_W = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_OVF        = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MIN        = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_FIRST_PEND = LEN_W'(FCS_BYTES + 1);
  localparam logic [LEN_W-1:0] LEN_FIRST_EMIT = LEN_W'(FCS_BYTES + 2);

  rx_state_t state, state_n;

  logic [31:0]                crc, crc_n, crc_calc;
  logic [LEN_W-1:0]           len, len_n, len_inc;
  logic [FCS_BYTES-1:0][7:0]  win, win_n;
  logic [7:0]                 pend, pend_n;
  logic                       sticky, sticky_n;
  logic [7:0]                 out_data_q, out_data_n;
  logic                       out_valid_q, out_valid_n;
  logic                       out_last_q, out_last_n;
  logic                       out_err_q, out_err_n;
  logic [CNT_W-1:0]           good_n, bad_n;
  logic                       dv, rx_er, frame_err;

  assign dv        = bus.rx_ctl[1];
  assign rx_er     = bus.rx_ctl[1] ^ bus.rx_ctl[0];
  assign len_inc   = len + LEN_W'(1);
  assign frame_err = sticky | (crc != CRC32_RESIDUE) | (len < LEN_MIN);

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_err   = out_err_q;

  crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (bus.rx_data),
    .crc_out (crc_calc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state, datapath updates and the output beat for this cycle
  always_comb begin
    state_n     = state;
    crc_n       = crc;
    len_n       = len;
    win_n       = win;
    pend_n      = pend;
    sticky_n    = sticky;
    out_data_n  = '0;
    out_valid_n = 1'b0;
    out_last_n  = 1'b0;
    out_err_n   = 1'b0;
    good_n      = cnt_good;
    bad_n       = cnt_bad;
    case (state)
      IDLE: begin
        crc_n    = CRC32_INIT;
        len_n    = '0;
        sticky_n = 1'b0;
        if (dv) begin
          if (bus.rx_data == ETH_PREAMBLE) state_n = PRE;
          else if (bus.rx_data == ETH_SFD) state_n = DATA;
          else                             state_n = DROP;
        end
      end
      PRE: begin
        crc_n    = CRC32_INIT;
        len_n    = '0;
        sticky_n = 1'b0;
        if (!dv)                              state_n = IDLE;
        else if (bus.rx_data == ETH_SFD)      state_n = DATA;
        else if (bus.rx_data != ETH_PREAMBLE) state_n = DROP;
      end
      DATA: begin
        if (dv) begin
          crc_n = crc_calc;
          len_n = len_inc;
          win_n = {win[FCS_BYTES-2:0], bus.rx_data};
          if (rx_er) sticky_n = 1'b1;
          if (len_inc == LEN_OVF) begin
            // Oversize: close the frame as bad on the byte still pending
            out_valid_n = 1'b1;
            out_last_n  = 1'b1;
            out_err_n   = 1'b1;
            out_data_n  = pend;
            bad_n       = cnt_bad + CNT_W'(1);
            state_n     = DROP;
          end else if (len_inc >= LEN_FIRST_PEND) begin
            pend_n = win[FCS_BYTES-1];
            if (len_inc >= LEN_FIRST_EMIT) begin
              out_valid_n = 1'b1;
              out_data_n  = pend;
            end
          end
        end else begin
          if (len >= LEN_FIRST_PEND) begin
            out_valid_n = 1'b1;
            out_last_n  = 1'b1;
            out_err_n   = frame_err;
            out_data_n  = pend;
            if (frame_err) bad_n  = cnt_bad + CNT_W'(1);
            else           good_n = cnt_good + CNT_W'(1);
          end else begin
            bad_n = cnt_bad + CNT_W'(1);
          end
          state_n = IDLE;
        end
      end
      DROP: begin
        if (!dv) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath, output and statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      crc         <= CRC32_INIT;
      len         <= '0;
      win         <= '0;
      pend        <= '0;
      sticky      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      cnt_good    <= '0;
      cnt_bad     <= '0;
    end else begin
      crc         <= crc_n;
      len         <= len_n;
      win         <= win_n;
      pend        <= pend_n;
      sticky      <= sticky_n;
      out_data_q  <= out_data_n;
      out_valid_q <= out_valid_n;
      out_last_q  <= out_last_n;
      out_err_q   <= out_err_n;
      cnt_good    <= good_n;
      cnt_bad     <= bad_n;
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Self-checking bench for gmii_rx_frame: frame-level reference model built from
// the byte list after the SFD, compared against the DUT every cycle.
module tb_gmii_rx_frame;

  localparam int MAX_LEN = 1518;
  localparam int MIN_LEN = 64;
  localparam int CNT_W   = 16;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       last;
    logic       err;
  } beat_t;

  typedef struct {
    int   cyc;
    logic good;
  } evt_t;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic [CNT_W-1:0] cnt_good, cnt_bad;

  gmii_rx_frame_if bus ();

  gmii_rx_frame #(
    .MAX_LEN (MAX_LEN),
    .MIN_LEN (MIN_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .cnt_good (cnt_good),
    .cnt_bad  (cnt_bad)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int               checks   = 0;
  int               failures = 0;
  beat_t            beat_q[$];
  evt_t             evt_q[$];
  logic [CNT_W-1:0] exp_good = '0;
  logic [CNT_W-1:0] exp_bad  = '0;
  int               beats_seen = 0;
  logic [7:0]       last_data  = '0;
  logic             last_err   = 1'b0;
  logic [7:0]       frame_q[$];
  beat_t            cur_beat;
  logic             exp_valid;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Standard CRC-32 (byte xor-in form), returns the FCS value to transmit
  function automatic logic [31:0] crc32_bytes(input logic [7:0] q[$], input int len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic applyStimulus(input logic dv, input logic er, input logic [7:0] data);
    @(negedge clk);
    bus.rx_ctl  = {dv, dv ^ er};
    bus.rx_data = data;
  endtask

  task automatic buildFrame(input int plen, input bit incr);
    logic [31:0] fcs;
    frame_q.delete();
    for (int i = 0; i < plen; i++) frame_q.push_back(incr ? 8'(i) : 8'($urandom_range(0, 255)));
    fcs = crc32_bytes(frame_q, plen);
    frame_q.push_back(fcs[7:0]);
    frame_q.push_back(fcs[15:8]);
    frame_q.push_back(fcs[23:16]);
    frame_q.push_back(fcs[31:24]);
  endtask

  // Frame-level expectations: payload byte j appears at sfd_cycle + j + 6;
  // the frame's counter update lands with the last beat (or 2 cycles after the final byte for runts)
  task automatic modelFrame(input int s, input int er_at);
    int          n;
    logic        err;
    logic [31:0] fcs;
    n = frame_q.size();
    if (n > MAX_LEN) begin
      for (int j = 1; j <= MAX_LEN - 4; j++)
        beat_q.push_back('{cyc: s + j + 6, data: frame_q[j-1], last: (j == MAX_LEN - 4), err: 1'b1});
      evt_q.push_back('{cyc: s + MAX_LEN + 2, good: 1'b0});
    end else if (n >= 5) begin
      fcs = crc32_bytes(frame_q, n - 4);
      err = (er_at >= 1 && er_at <= n) ||
            ({frame_q[n-1], frame_q[n-2], frame_q[n-3], frame_q[n-4]} != fcs) ||
            (n < MIN_LEN);
      for (int j = 1; j <= n - 4; j++)
        beat_q.push_back('{cyc: s + j + 6, data: frame_q[j-1], last: (j == n - 4), err: err});
      evt_q.push_back('{cyc: s + n + 2, good: !err});
    end else begin
      evt_q.push_back('{cyc: s + n + 2, good: 1'b0});
    end
  endtask

  // Drive preamble, SFD, frame_q bytes and idle cycles; optionally pulse reset mid-frame
  task automatic sendFrame(input int npre, input int er_at, input int idle, input int rst_at);
    int s;
    for (int i = 0; i < npre; i++) applyStimulus(1'b1, 1'b0, 8'h55);
    applyStimulus(1'b1, 1'b0, 8'hD5);
    s = cyc;
    modelFrame(s, er_at);
    for (int k = 1; k <= frame_q.size(); k++) begin
      applyStimulus(1'b1, (k == er_at), frame_q[k-1]);
      if (k == rst_at)     reset = 1'b1;
      if (k == rst_at + 2) reset = 1'b0;
    end
    for (int i = 0; i < idle; i++) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  // Per-cycle comparison of the DUT against the model queues
  always @(posedge clk) begin
    #1;
    if (reset) begin
      beat_q.delete();
      evt_q.delete();
      exp_good = '0;
      exp_bad  = '0;
      checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset_out_last", 32'(bus.out_last), 32'd0);
      checkOutput("reset_out_data", 32'(bus.out_data), 32'd0);
      checkOutput("reset_cnt_good", 32'(cnt_good), 32'd0);
      checkOutput("reset_cnt_bad", 32'(cnt_bad), 32'd0);
    end else begin
      while (evt_q.size() > 0 && evt_q[0].cyc <= cyc) begin
        if (evt_q[0].good) exp_good = exp_good + CNT_W'(1);
        else               exp_bad  = exp_bad + CNT_W'(1);
        void'(evt_q.pop_front());
      end
      checkOutput("cnt_good", 32'(cnt_good), 32'(exp_good));
      checkOutput("cnt_bad", 32'(cnt_bad), 32'(exp_bad));
      exp_valid = (beat_q.size() > 0) && (beat_q[0].cyc == cyc);
      checkOutput("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      if (exp_valid) begin
        cur_beat = beat_q.pop_front();
        if (bus.out_valid) begin
          checkOutput("out_data", 32'(bus.out_data), 32'(cur_beat.data));
          checkOutput("out_last", 32'(bus.out_last), 32'(cur_beat.last));
          if (cur_beat.last) checkOutput("out_err", 32'(bus.out_err), 32'(cur_beat.err));
        end
      end
      if (bus.out_valid) begin
        beats_seen++;
        if (bus.out_last) begin
          last_data = bus.out_data;
          last_err  = bus.out_err;
        end
      end
    end
  end

  int b0;

  initial begin
    bus.rx_ctl  = 2'b00;
    bus.rx_data = 8'h00;

    frame_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    checkOutput("model_crc_check_value", crc32_bytes(frame_q, 9), 32'hCBF43926);

    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);

    $display("[TB] good frame");
    b0 = beats_seen;
    buildFrame(60, 1'b1);
    sendFrame(7, 0, 2, 0);
    checkOutput("t1_beats", beats_seen - b0, 60);
    checkOutput("t1_last_data", 32'(last_data), 32'h3B);
    checkOutput("t1_last_err", 32'(last_err), 32'd0);
    checkOutput("t1_cnt_good", 32'(cnt_good), 32'd1);

    $display("[TB] bit flip");
    b0 = beats_seen;
    buildFrame(60, 1'b1);
    frame_q[20] = frame_q[20] ^ 8'h04;
    sendFrame(7, 0, 2, 0);
    checkOutput("t2_beats", beats_seen - b0, 60);
    checkOutput("t2_last_err", 32'(last_err), 32'd1);
    checkOutput("t2_cnt_bad", 32'(cnt_bad), 32'd1);
    checkOutput("t2_cnt_good", 32'(cnt_good), 32'd1);

    $display("[TB] rx_er");
    b0 = beats_seen;
    buildFrame(60, 1'b1);
    sendFrame(7, 10, 2, 0);
    checkOutput("t3_last_err", 32'(last_err), 32'd1);
    repeat (5) applyStimulus(1'b0, 1'b1, 8'hAA);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t3_beats", beats_seen - b0, 60);
    checkOutput("t3_cnt_bad", 32'(cnt_bad), 32'd2);
    checkOutput("t3_cnt_good", 32'(cnt_good), 32'd1);

    $display("[TB] length boundaries");
    b0 = beats_seen;
    buildFrame(1514, 1'b0);
    sendFrame(7, 0, 2, 0);
    checkOutput("t4_max_beats", beats_seen - b0, 1514);
    checkOutput("t4_max_err", 32'(last_err), 32'd0);
    checkOutput("t4_max_cnt_good", 32'(cnt_good), 32'd2);
    b0 = beats_seen;
    buildFrame(1515, 1'b0);
    sendFrame(7, 0, 2, 0);
    checkOutput("t4_ovf_beats", beats_seen - b0, 1514);
    checkOutput("t4_ovf_err", 32'(last_err), 32'd1);
    b0 = beats_seen;
    buildFrame(1517, 1'b0);
    sendFrame(7, 0, 2, 0);
    checkOutput("t4_ovf2_beats", beats_seen - b0, 1514);
    checkOutput("t4_ovf_cnt_bad", 32'(cnt_bad), 32'd4);
    b0 = beats_seen;
    frame_q = {8'h12, 8'h34, 8'h56};
    sendFrame(7, 0, 2, 0);
    checkOutput("t4_runt_beats", beats_seen - b0, 0);
    checkOutput("t4_runt_cnt_bad", 32'(cnt_bad), 32'd5);
    b0 = beats_seen;
    buildFrame(16, 1'b1);
    sendFrame(7, 0, 2, 0);
    checkOutput("t4_short_beats", beats_seen - b0, 16);
    checkOutput("t4_short_err", 32'(last_err), 32'd1);
    checkOutput("t4_short_cnt_bad", 32'(cnt_bad), 32'd6);

    $display("[TB] back-to-back and reset mid-frame");
    b0 = beats_seen;
    buildFrame(60, 1'b1);
    sendFrame(7, 0, 1, 0);
    buildFrame(60, 1'b1);
    sendFrame(7, 0, 2, 0);
    checkOutput("t5_beats", beats_seen - b0, 120);
    checkOutput("t5_cnt_good", 32'(cnt_good), 32'd4);
    buildFrame(60, 1'b1);
    sendFrame(7, 0, 2, 30);
    checkOutput("t5_rst_cnt_good", 32'(cnt_good), 32'd0);
    checkOutput("t5_rst_cnt_bad", 32'(cnt_bad), 32'd0);

    $display("[TB] malformed preamble");
    b0 = beats_seen;
    applyStimulus(1'b1, 1'b0, 8'h55);
    applyStimulus(1'b1, 1'b0, 8'h55);
    applyStimulus(1'b1, 1'b0, 8'hAA);
    applyStimulus(1'b1, 1'b0, 8'h11);
    applyStimulus(1'b1, 1'b0, 8'hD5);
    applyStimulus(1'b1, 1'b0, 8'h22);
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t6_drop_beats", beats_seen - b0, 0);
    checkOutput("t6_drop_cnt_bad", 32'(cnt_bad), 32'd0);
    buildFrame(60, 1'b1);
    sendFrame(7, 0, 2, 0);
    checkOutput("t6_next_beats", beats_seen - b0, 60);
    checkOutput("t6_next_cnt_good", 32'(cnt_good), 32'd1);

    $display("[TB] random frames");
    for (int f = 0; f < 40; f++) begin
      int mode;
      int er_at;
      mode  = $urandom_range(0, 9);
      er_at = 0;
      if (mode == 0) begin
        int n;
        n = $urandom_range(0, 4);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
      end else begin
        buildFrame($urandom_range(1, 100), 1'b0);
        if (mode == 1)
          frame_q[$urandom_range(0, frame_q.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
        if (mode == 2)
          er_at = $urandom_range(1, frame_q.size());
      end
      sendFrame($urandom_range(0, 8), er_at, $urandom_range(1, 3), 0);
    end

    repeat (10) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("beat_queue_drained", beat_q.size(), 0);
    checkOutput("event_queue_drained", evt_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
